// File: rtl/pwm_capture_if.sv
// pwm_capture_if: capture controls and measurement results of pwm_capture.
// master drives the controls and reads results; slave is the capture block.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             i_pwm;
  logic [CNT_W-1:0] i_timeout;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_valid;
  logic             o_stuck_high;
  logic             o_stuck_low;
  logic             o_ovf;

  modport master (
    output en,
    output i_pwm,
    output i_timeout,
    input  o_period,
    input  o_high,
    input  o_valid,
    input  o_stuck_high,
    input  o_stuck_low,
    input  o_ovf
  );

  modport slave (
    input  en,
    input  i_pwm,
    input  i_timeout,
    output o_period,
    output o_high,
    output o_valid,
    output o_stuck_high,
    output o_stuck_low,
    output o_ovf
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input between rises,
// with stuck-high/low timeout detection and a sticky overflow flag.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  pwm_capture_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise;

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] pcnt_inc, hcnt_inc;
  logic             valid_q, valid_d;
  logic             sth_q, sth_d;
  logic             stl_q, stl_d;
  logic             ovf_q, ovf_d;
  logic             expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_pwm};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  assign pcnt_inc = (pcnt_q == ONES) ? pcnt_q : pcnt_q + ONE;
  assign hcnt_inc = (hcnt_q == ONES) ? hcnt_q : hcnt_q + ONE;

  // A rise in the expiry cycle takes priority over the timeout.
  assign expire = (bus.i_timeout != '0) &&
                  (pcnt_q == bus.i_timeout) && !rise;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    sth_d    = sth_q;
    stl_d    = stl_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        pcnt_d  = '0;
        hcnt_d  = '0;
        state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          pcnt_d  = ONE;
          hcnt_d  = ONE;
          sth_d   = 1'b0;
          stl_d   = 1'b0;
          state_d = MEASURE;
        end else if (expire) begin
          if (s) sth_d = 1'b1;
          else   stl_d = 1'b1;
          period_d = '0;
          high_d   = '0;
          pcnt_d   = ONE;
          hcnt_d   = '0;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = pcnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          pcnt_d   = ONE;
          hcnt_d   = ONE;
          sth_d    = 1'b0;
          stl_d    = 1'b0;
          if (pcnt_q == ONES) ovf_d = 1'b1;
        end else if (expire) begin
          if (s) sth_d = 1'b1;
          else   stl_d = 1'b1;
          period_d = '0;
          high_d   = '0;
          pcnt_d   = ONE;
          hcnt_d   = '0;
          state_d  = ARM;
        end else begin
          pcnt_d = pcnt_inc;
          if (s) hcnt_d = hcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.en) begin
      state_d  = IDLE;
      pcnt_d   = '0;
      hcnt_d   = '0;
      period_d = '0;
      high_d   = '0;
      valid_d  = 1'b0;
      sth_d    = 1'b0;
      stl_d    = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      sth_q    <= 1'b0;
      stl_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      sth_q    <= sth_d;
      stl_q    <= stl_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.o_period     = period_q;
  assign bus.o_high       = high_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_stuck_high = sth_q;
  assign bus.o_stuck_low  = stl_q;
  assign bus.o_ovf        = ovf_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random PWM streams checked against a
// period/high-time scoreboard derived from the driven waveform.
module tb_pwm_capture;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int p;
    int h;
  } meas_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_valid = 0;
  int    cyc = 0;
  int    last_valid_cyc = 0;
  bit    have_prev = 1'b0;
  int    prev_p = 0;
  int    prev_h = 0;
  meas_t exp_q[$];
  meas_t mon_m;

  pwm_capture_if #(.CNT_W(W)) bus ();

  pwm_capture #(
    .CNT_W(W),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int sat(int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every result strobe must match the oldest completed driven period.
  always @(posedge clk) begin
    #1;
    if (bus.o_valid !== 1'b0) begin
      n_valid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", bus.o_valid, 0);
      end else begin
        mon_m = exp_q.pop_front();
        check("period", bus.o_period, mon_m.p);
        check("high", bus.o_high, mon_m.h);
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_rise(int p, int h);
    bus.i_pwm = 1'b1;
    if (have_prev) exp_q.push_back(meas_t'{sat(prev_p), sat(prev_h)});
    have_prev = 1'b1;
    prev_p = p;
    prev_h = h;
  endtask

  task automatic pwm_period(int p, int h);
    start_rise(p, h);
    cycles(h);
    bus.i_pwm = 1'b0;
    cycles(p - h);
  endtask

  task automatic close_stream(string tag);
    start_rise(2, 1);
    cycles(1);
    bus.i_pwm = 1'b0;
    cycles(6);
    check({tag, "_pending"}, exp_q.size(), 0);
    bus.en = 1'b0;
    cycles(2);
    have_prev = 1'b0;
    bus.en = 1'b1;
    cycles(2);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_period"}, bus.o_period, 0);
    check({tag, "_high"}, bus.o_high, 0);
    check({tag, "_valid"}, bus.o_valid, 0);
    check({tag, "_sth"}, bus.o_stuck_high, 0);
    check({tag, "_stl"}, bus.o_stuck_low, 0);
    check({tag, "_ovf"}, bus.o_ovf, 0);
  endtask

  task automatic wait_stuck(bit hi, int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if ((hi ? bus.o_stuck_high : bus.o_stuck_low) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at;
    int p;
    int h;
    int v0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.i_pwm = 1'b0;
    bus.i_timeout = '0;
    cycles(3);
    check_zero("reset");
    rst = 1'b0;
    cycles(1);
    bus.en = 1'b1;
    cycles(2);

    // steady 16/4, five periods
    v0 = n_valid;
    repeat (5) pwm_period(16, 4);
    check("t1_valids", n_valid - v0, 4);
    check("t1_sth", bus.o_stuck_high, 0);
    check("t1_stl", bus.o_stuck_low, 0);
    check("t1_ovf", bus.o_ovf, 0);
    close_stream("t1");

    // duty change mid-stream
    repeat (4) pwm_period(16, 4);
    repeat (4) pwm_period(16, 12);
    close_stream("t2");

    // random periods, timeout never reached
    bus.i_timeout = W'(200);
    repeat (25) begin
      p = $urandom_range(40, 2);
      h = $urandom_range(p - 1, 1);
      pwm_period(p, h);
    end
    check("rand_sth", bus.o_stuck_high, 0);
    check("rand_stl", bus.o_stuck_low, 0);
    close_stream("rand");

    // stuck low
    bus.i_timeout = W'(100);
    repeat (3) pwm_period(16, 4);
    wait_stuck(1'b0, 300, at);
    @(negedge clk);
    have_prev = 1'b0;
    check("t3_stl", bus.o_stuck_low, 1);
    check("t3_delay", at - last_valid_cyc, 100);
    check("t3_period", bus.o_period, 0);
    check("t3_high", bus.o_high, 0);
    check("t3_sth", bus.o_stuck_high, 0);
    cycles(100);
    check("t3_rearm", bus.o_stuck_low, 1);
    pwm_period(10, 3);
    check("t3_clear", bus.o_stuck_low, 0);
    repeat (2) pwm_period(10, 3);
    close_stream("t3");

    // stuck high
    bus.i_timeout = W'(50);
    start_rise(0, 0);
    wait_stuck(1'b1, 200, at);
    @(negedge clk);
    have_prev = 1'b0;
    check("t4_sth", bus.o_stuck_high, 1);
    check("t4_stl", bus.o_stuck_low, 0);
    check("t4_period", bus.o_period, 0);
    check("t4_high", bus.o_high, 0);
    bus.i_pwm = 1'b0;
    cycles(3);
    pwm_period(10, 4);
    check("t4_clear", bus.o_stuck_high, 0);
    repeat (3) pwm_period(10, 4);
    check("t4_stl_end", bus.o_stuck_low, 0);
    close_stream("t4");

    // overflow and saturation
    bus.i_timeout = '0;
    pwm_period(300, 100);
    check("t5_ovf_pre", bus.o_ovf, 0);
    pwm_period(300, 100);
    check("t5_ovf", bus.o_ovf, 1);
    pwm_period(300, 280);
    repeat (3) pwm_period(20, 5);
    check("t5_ovf_sticky", bus.o_ovf, 1);
    close_stream("t5");
    check("t5_ovf_clr", bus.o_ovf, 0);

    // rise coincides with timeout expiry
    bus.i_timeout = W'(20);
    repeat (4) pwm_period(20, 7);
    check("t7_sth", bus.o_stuck_high, 0);
    check("t7_stl", bus.o_stuck_low, 0);
    close_stream("t7");

    // async reset mid-period
    bus.i_timeout = '0;
    repeat (2) pwm_period(16, 4);
    start_rise(16, 4);
    cycles(6);
    #2;
    rst = 1'b1;
    #1;
    check_zero("t6_rst");
    bus.i_pwm = 1'b0;
    have_prev = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(3);
    repeat (3) pwm_period(12, 5);
    close_stream("t6r");

    // enable drop mid-period
    repeat (2) pwm_period(16, 4);
    start_rise(16, 4);
    cycles(6);
    bus.en = 1'b0;
    cycles(1);
    check_zero("t6_en");
    bus.i_pwm = 1'b0;
    have_prev = 1'b0;
    cycles(2);
    bus.en = 1'b1;
    cycles(2);
    repeat (3) pwm_period(12, 5);
    close_stream("t6e");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
